// File: rtl/ttt_pkg.sv
// ============================================================================
//  Module      : ttt_pkg
//  Description : Shared cell/winner codes, FSM state type and the winning
//                line table for the tic-tac-toe game controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

    // Cell occupancy codes, 2 bits per cell on the board bus
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_O     = 2'b01;
    localparam logic [1:0] CELL_X     = 2'b10;

    // Game result codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_O    = 2'b01;
    localparam logic [1:0] WIN_X    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    typedef enum logic [2:0] {
        S_RELEASE = 3'd0,
        S_WAIT    = 3'd1,
        S_PLACE   = 3'd2,
        S_CHECK   = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    // Cell index triples; line l occupies LINES[l]. Listed from line 7 down
    // to line 0: rows 0-2, cols 0-2, main diagonal, anti-diagonal.
    localparam logic [NUM_LINES-1:0][2:0][3:0] LINES = {
        {4'd2, 4'd4, 4'd6},   // 7: anti-diagonal
        {4'd0, 4'd4, 4'd8},   // 6: main diagonal
        {4'd2, 4'd5, 4'd8},   // 5: col 2
        {4'd1, 4'd4, 4'd7},   // 4: col 1
        {4'd0, 4'd3, 4'd6},   // 3: col 0
        {4'd6, 4'd7, 4'd8},   // 2: row 2
        {4'd3, 4'd4, 4'd5},   // 1: row 1
        {4'd0, 4'd1, 4'd2}    // 0: row 0
    };

endpackage

`default_nettype wire

// File: rtl/ttt_debounce.sv
// ============================================================================
//  Module      : ttt_debounce
//  Description : Two-flop synchronizer followed by a debouncer that shares a
//                single stability counter across the whole input vector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] raw_vec,
    output logic [WIDTH-1:0] db_vec,
    output logic             settled
);

    localparam logic [DB_W-1:0] c_cnt_max = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_db_vec;
    logic [DB_W-1:0]  r_cnt;

    // Bring the asynchronous buttons into the clock domain (idle = released)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= raw_vec;
            r_sync2 <= r_sync1;
        end
    end

    // Any change restarts the window; a full stable window publishes the vector
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_prev   <= '1;
            r_cnt    <= '0;
            r_db_vec <= '1;
        end else begin
            r_prev <= r_sync2;
            if (r_sync2 != r_prev) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + DB_W'(1);
            end else begin
                r_db_vec <= r_prev;
            end
        end
    end

    assign db_vec  = r_db_vec;
    // Debounced output agrees with a fully aged synchronized input, so no
    // change is still working its way through the window.
    assign settled = (r_cnt == c_cnt_max) && (r_prev == r_db_vec) && (r_sync2 == r_prev);

endmodule

`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
// ============================================================================
//  Module      : ttt_game_ctrl
//  Description : Tic-tac-toe game controller: debounced button input, turn
//                FSM, win/draw detection and a blanking-synchronized board
//                shadow for the VGA renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [8:0]  board_but,
    input  logic        new_game_n,
    input  logic        vnotactive,
    output logic [17:0] board_out,
    output logic        player,
    output logic [1:0]  winner,
    output logic [7:0]  win_line
);

    logic [9:0]           w_db_vec;
    logic                 w_settled;
    logic [1:0]           w_code;
    logic                 w_sel_valid;
    logic [3:0]           w_sel_idx;
    logic [NUM_LINES-1:0] w_line_hit;

    state_t               r_state;
    logic [17:0]          r_board;
    logic [17:0]          r_board_out;
    logic [3:0]           r_cell;
    logic [3:0]           r_move_cnt;
    logic                 r_player;
    logic [1:0]           r_winner;
    logic [7:0]           r_win_line;

    ttt_debounce #(
        .WIDTH           (10),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_debounce (
        .CLK     (CLK),
        .RST     (RST),
        .raw_vec ({new_game_n, board_but}),
        .db_vec  (w_db_vec),
        .settled (w_settled)
    );

    // Mark of the player to move: O -> 01, X -> 10
    assign w_code = {r_player, ~r_player};

    // Lowest-index pressed cell that is still empty (scan high to low so the lowest wins)
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (!w_db_vec[i] && (r_board[2*i +: 2] == CELL_EMPTY)) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = 4'(i);
            end
        end
    end

    // One comparator per line against the current player's mark
    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        assign w_line_hit[l] = (r_board[2*int'(LINES[l][0]) +: 2] == w_code) &&
                               (r_board[2*int'(LINES[l][1]) +: 2] == w_code) &&
                               (r_board[2*int'(LINES[l][2]) +: 2] == w_code);
    end

    // Turn FSM: accept one press per release cycle, place, then score the move
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_RELEASE;
            r_board    <= '0;
            r_cell     <= '0;
            r_move_cnt <= '0;
            r_player   <= 1'b0;
            r_winner   <= WIN_NONE;
            r_win_line <= '0;
        end else begin
            case (r_state)
                // Waiting for settled all-released buttons also blocks a
                // button held through reset from being seen as a fresh press.
                S_RELEASE: begin
                    if ((&w_db_vec) && w_settled) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_db_vec[9]) begin
                        r_board    <= '0;
                        r_move_cnt <= '0;
                        r_player   <= 1'b0;
                        r_winner   <= WIN_NONE;
                        r_win_line <= '0;
                        r_state    <= S_RELEASE;
                    end else if (w_sel_valid) begin
                        r_cell  <= w_sel_idx;
                        r_state <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    r_board[{r_cell, 1'b0} +: 2] <= w_code;
                    r_move_cnt <= r_move_cnt + 4'd1;
                    r_state    <= S_CHECK;
                end
                S_CHECK: begin
                    if (|w_line_hit) begin
                        r_win_line <= w_line_hit;
                        r_winner   <= w_code;
                        r_state    <= S_OVER;
                    end else if (r_move_cnt == 4'd9) begin
                        r_winner <= WIN_DRAW;
                        r_state  <= S_OVER;
                    end else begin
                        r_player <= ~r_player;
                        r_state  <= S_RELEASE;
                    end
                end
                S_OVER: begin
                    if (!w_db_vec[9]) begin
                        r_board    <= '0;
                        r_move_cnt <= '0;
                        r_player   <= 1'b0;
                        r_winner   <= WIN_NONE;
                        r_win_line <= '0;
                        r_state    <= S_RELEASE;
                    end
                end
                default: r_state <= S_RELEASE;
            endcase
        end
    end

    // Shadow board only moves during vertical blanking to avoid tearing
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_board_out <= '0;
        end else if (vnotactive) begin
            r_board_out <= r_board;
        end
    end

    assign board_out = r_board_out;
    assign player    = r_player;
    assign winner    = r_winner;
    assign win_line  = r_win_line;

endmodule

`default_nettype wire
